add_reservation_station: RTL

Reservation station feeding the integer add/sub functional unit of the Tomasulo core. It accepts issued add/sub instructions with operands as values or producer tags, and snoops the common data bus (CDB) to capture pending operands. It dispatches one ready entry at a time to the adder through its start/SrcA/SrcB/Tag handshake. An entry is freed when the adder signals release after its result has been broadcast.

---
 rtl/add_reservation_station.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/add_reservation_station.sv
// Reservation station for the integer add/sub unit: holds issued operations, snoops the
// CDB for pending operands and dispatches the lowest-index ready entry to the adder.
module add_reservation_station #(
    parameter int ENTRIES  = 3,
    parameter int TAG_BASE = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        issue_valid,
    input  logic        issue_sub,
    input  logic [3:0]  issue_qj,
    input  logic [3:0]  issue_qk,
    input  logic [31:0] issue_vj,
    input  logic [31:0] issue_vk,
    output logic        rs_full,
    output logic [3:0]  issue_tag,
    input  logic        cdb_valid,
    input  logic [3:0]  cdb_tag,
    input  logic [31:0] cdb_data,
    output logic        fu_start,
    output logic [31:0] fu_srca,
    output logic [31:0] fu_srcb,
    output logic [3:0]  fu_tag,
    input  logic        fu_release
);

    typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} entry_state_t;

    entry_state_t state_q [ENTRIES];
    entry_state_t state_d [ENTRIES];
    logic [3:0]   qj_q    [ENTRIES];
    logic [3:0]   qj_d    [ENTRIES];
    logic [3:0]   qk_q    [ENTRIES];
    logic [3:0]   qk_d    [ENTRIES];
    logic [31:0]  vj_q    [ENTRIES];
    logic [31:0]  vj_d    [ENTRIES];
    logic [31:0]  vk_q    [ENTRIES];
    logic [31:0]  vk_d    [ENTRIES];
    logic         sub_q   [ENTRIES];
    logic         sub_d   [ENTRIES];

    logic               fu_busy;
    logic               free_found;
    logic [ENTRIES-1:0] free_sel;
    logic [3:0]         free_tag;
    logic               ready_found;
    logic [ENTRIES-1:0] ready_sel;
    logic [31:0]        disp_vj;
    logic [31:0]        disp_vk;
    logic               disp_sub;
    logic [3:0]         disp_tag;
    logic               do_issue;
    logic               do_dispatch;
    logic               fwd_j;
    logic               fwd_k;

    // Priority pick of the lowest-index FREE and READY entries, from registered state only.
    always_comb begin
        free_found  = 1'b0;
        free_sel    = '0;
        free_tag    = 4'(TAG_BASE);
        ready_found = 1'b0;
        ready_sel   = '0;
        disp_vj     = '0;
        disp_vk     = '0;
        disp_sub    = 1'b0;
        disp_tag    = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (state_q[i] == FREE) begin
                free_found  = 1'b1;
                free_sel    = '0;
                free_sel[i] = 1'b1;
                free_tag    = 4'(TAG_BASE + i);
            end
            if (state_q[i] == READY) begin
                ready_found  = 1'b1;
                ready_sel    = '0;
                ready_sel[i] = 1'b1;
                disp_vj      = vj_q[i];
                disp_vk      = vk_q[i];
                disp_sub     = sub_q[i];
                disp_tag     = 4'(TAG_BASE + i);
            end
        end
    end

    assign rs_full     = !free_found;
    assign issue_tag   = free_tag;
    assign do_issue    = issue_valid && free_found;
    assign do_dispatch = !fu_busy && ready_found;
    assign fwd_j       = (issue_qj != 4'd0) && cdb_valid && (cdb_tag == issue_qj);
    assign fwd_k       = (issue_qk != 4'd0) && cdb_valid && (cdb_tag == issue_qk);

    always_comb begin
        for (int i = 0; i < ENTRIES; i++) begin
            state_d[i] = state_q[i];
            qj_d[i]    = qj_q[i];
            qk_d[i]    = qk_q[i];
            vj_d[i]    = vj_q[i];
            vk_d[i]    = vk_q[i];
            sub_d[i]   = sub_q[i];
            if (state_q[i] == WAIT) begin
                if (cdb_valid && cdb_tag != 4'd0 && cdb_tag == qj_q[i]) begin
                    vj_d[i] = cdb_data;
                    qj_d[i] = 4'd0;
                end
                if (cdb_valid && cdb_tag != 4'd0 && cdb_tag == qk_q[i]) begin
                    vk_d[i] = cdb_data;
                    qk_d[i] = 4'd0;
                end
                if (qj_d[i] == 4'd0 && qk_d[i] == 4'd0) begin
                    state_d[i] = READY;
                end
            end
            if (ready_sel[i] && do_dispatch) begin
                state_d[i] = EXEC;
            end
            // A released entry only becomes allocatable on the following cycle.
            if (state_q[i] == EXEC && fu_release) begin
                state_d[i] = FREE;
            end
            if (free_sel[i] && do_issue) begin
                sub_d[i]   = issue_sub;
                qj_d[i]    = fwd_j ? 4'd0 : issue_qj;
                qk_d[i]    = fwd_k ? 4'd0 : issue_qk;
                vj_d[i]    = fwd_j ? cdb_data : issue_vj;
                vk_d[i]    = fwd_k ? cdb_data : issue_vk;
                state_d[i] = (qj_d[i] == 4'd0 && qk_d[i] == 4'd0) ? READY : WAIT;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= FREE;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                sub_q[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                state_q[i] <= state_d[i];
                qj_q[i]    <= qj_d[i];
                qk_q[i]    <= qk_d[i];
                vj_q[i]    <= vj_d[i];
                vk_q[i]    <= vk_d[i];
                sub_q[i]   <= sub_d[i];
            end
        end
    end

    // Dispatch operands and tag stay put between pulses; the adder watches fu_tag every cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fu_busy  <= 1'b0;
            fu_start <= 1'b0;
            fu_srca  <= '0;
            fu_srcb  <= '0;
            fu_tag   <= '0;
        end else begin
            fu_start <= do_dispatch;
            if (do_dispatch) begin
                fu_busy <= 1'b1;
                fu_srca <= disp_vj;
                fu_srcb <= disp_sub ? (~disp_vk + 32'd1) : disp_vk;
                fu_tag  <= disp_tag;
            end else if (fu_release) begin
                fu_busy <= 1'b0;
            end
        end
    end

endmodule
